// File: rtl/cp0_regfile_pkg.sv
// CP0 shared definitions: register numbers, ExcCodes, Status/Cause bit
// positions and the per-register software write masks.
package cp0_regfile_pkg;

  typedef enum logic [4:0] {
    CP0_BADVADDR = 5'd8,
    CP0_COUNT    = 5'd9,
    CP0_COMPARE  = 5'd11,
    CP0_STATUS   = 5'd12,
    CP0_CAUSE    = 5'd13,
    CP0_EPC      = 5'd14
  } cp0_reg_e;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_BEV = 22;
  localparam int CA_TI  = 30;
  localparam int CA_BD  = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] BEV_MASK     = 32'h0040_0000;

  // Bits of each register an MTC0 may change; 0 for read-only/unmapped
  function automatic logic [31:0] cp0_wmask(input logic [4:0] addr);
    case (addr)
      CP0_COUNT, CP0_COMPARE, CP0_EPC: cp0_wmask = 32'hFFFF_FFFF;
      CP0_STATUS:                      cp0_wmask = STATUS_WMASK;
      CP0_CAUSE:                       cp0_wmask = CAUSE_WMASK;
      default:                         cp0_wmask = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: divided Count, Compare register and sticky TI flag.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [31:0]      r_count;
  logic [31:0]      r_compare;
  logic             r_ti;

  // Count advances once per COUNT_DIV cycles; a software load restarts the divider
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_count <= '0;
    end else if (count_we_i) begin
      r_div   <= '0;
      r_count <= wdata_i;
    end else if (r_div == DIV_LAST) begin
      r_div   <= '0;
      r_count <= r_count + 32'd1;
    end else begin
      r_div   <= r_div + 1'b1;
    end
  end

  // Compare load; TI is sticky on match and cleared by any Compare write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (compare_we_i) r_compare <= wdata_i;
      if (compare_we_i)                r_ti <= 1'b0;
      else if (r_count == r_compare)   r_ti <= 1'b1;
    end
  end

  assign count_o   = r_count;
  assign compare_o = r_compare;
  assign ti_o      = r_ti;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MFC0/MTC0 responder, exception/ERET state and
// interrupt request. Optional macro CP0_BYPASS_EN forwards a same-cycle
// MTC0 to the MFC0 read port.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_bd_i,
  input  logic [31:0] exc_badvaddr_i,
  input  logic        eret_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        int_pending_o
);

  logic [31:0] r_badvaddr, r_epc;
  logic [7:0]  r_im;
  logic        r_exl, r_ie, r_bd;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exc_code;

  logic [31:0] w_count, w_compare, w_status, w_cause, w_reg;
  logic        w_ti;
  logic        w_wr_status, w_wr_cause, w_wr_epc;

  assign w_wr_status = we_i && (waddr_i == CP0_STATUS);
  assign w_wr_cause  = we_i && (waddr_i == CP0_CAUSE);
  assign w_wr_epc    = we_i && (waddr_i == CP0_EPC);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (we_i && (waddr_i == CP0_COUNT)),
    .compare_we_i (we_i && (waddr_i == CP0_COMPARE)),
    .wdata_i      (wdata_i),
    .count_o      (w_count),
    .compare_o    (w_compare),
    .ti_o         (w_ti)
  );

  // Status: MTC0 < ERET < exception on EXL; IM/IE only ever come from MTC0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_im  <= STATUS_RST[15:8];
      r_exl <= STATUS_RST[ST_EXL];
      r_ie  <= STATUS_RST[ST_IE];
    end else begin
      if (w_wr_status) begin
        r_im  <= wdata_i[15:8];
        r_exl <= wdata_i[ST_EXL];
        r_ie  <= wdata_i[ST_IE];
      end
      if (eret_i)      r_exl <= 1'b0;
      if (exc_valid_i) r_exl <= 1'b1;
    end
  end

  // Cause IP sampling, soft IP, and exception-owned BD/ExcCode/EPC/BadVAddr
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ip_hw    <= '0;
      r_ip_sw    <= '0;
      r_bd       <= 1'b0;
      r_exc_code <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      r_ip_hw <= int_i;
      if (w_wr_cause) r_ip_sw <= wdata_i[9:8];
      if (exc_valid_i) begin
        // A nested exception (EXL already set) keeps the original return point
        if (!r_exl) begin
          r_epc <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
          r_bd  <= exc_bd_i;
        end
        r_exc_code <= exc_code_i;
        if (exc_code_i == EXC_ADEL || exc_code_i == EXC_ADES)
          r_badvaddr <= exc_badvaddr_i;
      end else if (w_wr_epc) begin
        r_epc <= wdata_i;
      end
    end
  end

  assign w_status = BEV_MASK | {16'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, w_ti, 14'b0, r_ip_hw[5] | w_ti, r_ip_hw[4:0],
                     r_ip_sw, 1'b0, r_exc_code, 2'b0};

  // Registered-value read mux, optionally merged with an in-flight MTC0
  always_comb begin
    w_reg = 32'h0;
    case (raddr_i)
      CP0_BADVADDR: w_reg = r_badvaddr;
      CP0_COUNT:    w_reg = w_count;
      CP0_COMPARE:  w_reg = w_compare;
      CP0_STATUS:   w_reg = w_status;
      CP0_CAUSE:    w_reg = w_cause;
      CP0_EPC:      w_reg = r_epc;
      default:      w_reg = 32'h0;
    endcase
`ifdef CP0_BYPASS_EN
    if (we_i && (waddr_i == raddr_i))
      rdata_o = (w_reg & ~cp0_wmask(raddr_i)) | (wdata_i & cp0_wmask(raddr_i));
    else
      rdata_o = w_reg;
`else
    rdata_o = w_reg;
`endif
  end

  assign status_o      = w_status;
  assign cause_o       = w_cause;
  assign epc_o         = r_epc;
  assign int_pending_o = r_ie & ~r_exl & (|(w_cause[15:8] & w_status[15:8]));

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- System coprocessor 0 register file: the responder side of the ALU's MFC0/MTC0 path.
- The ALU reads `rdata_o` as its cp0data operand; the MTC0 result (rt value) is written back here.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Latches exception state, runs the Count/Compare timer and raises the interrupt request to the exception logic.

Parameters:
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, all else 0).
- COUNT_DIV, 2, clk cycles per Count increment (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- we_i  in  1  MTC0 write enable (writeback stage)
- waddr_i  in  5  MTC0 destination register number (rd field)
- wdata_i  in  32  MTC0 write data
- raddr_i  in  5  MFC0 source register number
- rdata_o  out  32  MFC0 read data to ALU cp0data
- int_i  in  6  hardware interrupt lines, level-sensitive
- exc_valid_i  in  1  exception commit strobe, one cycle
- exc_code_i  in  5  ExcCode of committed exception
- exc_pc_i  in  32  PC of faulting instruction
- exc_bd_i  in  1  faulting instruction is in a branch delay slot
- exc_badvaddr_i  in  32  faulting address (AdEL/AdES)
- eret_i  in  1  ERET commit strobe
- status_o  out  32  current Status
- cause_o  out  32  current Cause
- epc_o  out  32  current EPC
- int_pending_o  out  1  enabled interrupt present

Behaviour:
Reset:
- BadVAddr, Count, Compare, Cause and EPC all 0.
- Status = STATUS_RST.
- Divider counter = 0.
- All outputs reflect these values in the cycle after rst is sampled high.
- rst overrides every other input in the same cycle.

Register map:
- 8 BadVAddr: read-only.
- 9 Count.
- 11 Compare.
- 12 Status: writable bits IM[15:8], EXL[1], IE[0]; BEV[22] reads constant 1; all other bits read 0.
- 13 Cause:
  - BD[31] and TI[30] read-only.
  - IP[15:10] is loaded every cycle from `int_i`, so it carries one cycle of latency.
  - IP[9:8] are software writable.
  - ExcCode[6:2] is read-only.
  - All other bits read 0.
- 14 EPC: read/write.
- Unlisted register numbers read 0 and ignore writes.

Read:
- Combinational: `rdata_o` = register selected by `raddr_i` (zero latency).

Count:
- Increments by 1, wrapping from 32'hFFFF_FFFF to 0, once every COUNT_DIV cycles.
- An MTC0 to Count loads `wdata_i` and resets the divider; that cycle has no increment.

Timer:
- TI sets when Count == Compare. The comparison uses registered values, so TI asserts the cycle after equality is reached.
- TI is sticky.
- An MTC0 to Compare clears TI; if the same cycle would also set it, the clear wins.
- Cause.IP[15] (IP7) = IP7 hardware line OR TI.

Exception (exc_valid_i=1):
- If Status.EXL==0: EPC <= exc_bd_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD <= exc_bd_i.
- If EXL==1: EPC and BD are held.
- Always: EXL <= 1 and ExcCode <= exc_code_i.
- If exc_code_i is 4 (AdEL) or 5 (AdES): BadVAddr <= exc_badvaddr_i.

ERET (eret_i=1):
- EXL <= 0.

Same-cycle priority:
- Exception > ERET > MTC0.
- A lower-priority write is dropped only for fields touched by the higher-priority event. Example: an MTC0 to Status.IM during an exception still updates IM, while EXL is forced to 1.

Interrupt:
- int_pending_o = IE & ~EXL & |(Cause[15:8] & Status[15:8]).
- Combinational from registered state.

Optional Feature:
CP0_BYPASS_EN:
- Defined: when we_i=1 and waddr_i==raddr_i, `rdata_o` returns `wdata_i` filtered through the target's write mask, merged with the current read-only bits. This resolves an MTC0→MFC0 hazard without a stall.
- Undefined: `rdata_o` always returns the registered value. The pipeline must interlock.

Decomposition:
- Shared header cp0defines.vh (alongside aludefines.vh) holds:
  - register numbers (CP0_BADVADDR=8 … CP0_EPC=14);
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12);
  - Status/Cause bit positions and write masks.
- One sub-module, cp0_timer, contains the Count, divider, Compare and TI logic. It exports count, compare and ti, and takes the write strobes.

Test Plan:
1. Reset, then read all six registers → Status=32'h0040_0000, all others 0. Read regno 3 → 0.
2. Hold idle for 20 cycles with COUNT_DIV=2 → Count=10. MTC0 Count=32'hFFFF_FFFF, then wait 2 cycles → Count=0 (wrap).
3. MTC0 Compare=5, Count=0, Status=32'h0000_8001 (IM7, IE) → TI and int_pending_o rise the cycle after Count==5. MTC0 Compare=9 → TI=0 and int_pending_o=0 next cycle.
4. Exception with code 4, pc=32'hBFC0_0104, bd=1, badvaddr=32'h1 → EPC=32'hBFC0_0100, BD=1, ExcCode=4, BadVAddr=1, EXL=1. Then a second exception with pc=32'h8000_0000 → EPC unchanged, ExcCode updated. Then ERET → EXL=0.
5. Same cycle: exception plus ERET plus MTC0 Status=0 → EXL=1, IM=0, IE=0.
6. With CP0_BYPASS_EN: MTC0 EPC=32'h1234 with raddr=14 in the same cycle → rdata_o=32'h1234 that cycle. Without the macro → rdata_o=old EPC.
